// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced three-step A/B/op operand entry for the 4-bit ALU
module alu_operand_loader_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d, prev_q, prev_d, pulse_q, pulse_d, diff, done;
  always_comb begin
    sync_d   = {sync_q[0], btn};
    diff     = sync_q[1] != stable_q;
    done     = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d    = (!diff || done) ? '0 : cnt_q + CW'(1);
    stable_d = done ? ~stable_q : stable_q;
    prev_d   = stable_q;
    pulse_d  = stable_q & ~prev_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
    end
  assign pulse = pulse_q;
endmodule

module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int W = 4
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic [W-1:0] SW,
  input  logic         BTNC,
  input  logic         BTNU,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [1:0]   op,
  output logic         valid,
  output logic [3:0]   LED
);
  typedef enum logic [1:0] {S_A, S_B, S_OP, S_RUN} state_t;
  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic         valid_q, valid_d, enter_p, cancel_p;
  alu_operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .btn(BTNC), .pulse(enter_p)
  );
  alu_operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .btn(BTNU), .pulse(cancel_p)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (cancel_p) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
    end else if (enter_p) begin
      case (state_q)
        S_A: begin
          a_d     = SW;
          state_d = S_B;
        end
        S_B: begin
          b_d     = SW;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = SW[1:0];
          valid_d = 1'b1;
          state_d = S_RUN;
        end
        default: begin
          a_d     = SW;
          valid_d = 1'b0;
          state_d = S_B;
        end
      endcase
    end
  end
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  assign A     = a_q;
  assign B     = b_q;
  assign op    = op_q;
  assign valid = valid_q;
  assign LED   = 4'b0001 << state_q;
endmodule
